// File: rtl/sva_pkg.sv
// Shared definitions for the SVA result collector: event-mask bit positions,
// verdict encoding and the event-log entry layout.
package sva_pkg;

    localparam int unsigned EVT_SUCC = 0;
    localparam int unsigned EVT_FAIL = 1;
    localparam int unsigned EVT_LAZY = 2;

    localparam int unsigned SVA_TS_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PASSING = 2'd1,
        FAILED  = 2'd2
    } sva_status_t;

    typedef struct packed {
        logic [2:0]              mask;
        logic [SVA_TS_WIDTH-1:0] ts;
    } sva_evt_t;

endpackage

// File: rtl/sva_result_collector_if.sv
// Event-log drain handshake: the collector presents the FIFO head, the consumer
// accepts it with evt_ready.
interface sva_result_collector_if #(
    parameter int unsigned TS_WIDTH = 16
) ();
    logic                evt_valid;
    logic                evt_ready;
    logic [2:0]          evt_mask;
    logic [TS_WIDTH-1:0] evt_ts;

    modport master (output evt_valid, output evt_mask, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_mask, input evt_ts, output evt_ready);
endinterface

// File: rtl/sva_evt_fifo.sv
// Synchronous event-log FIFO with a registered head and valid/ready drain.
// DEPTH must be a power of two, at least 2.
module sva_evt_fifo
    import sva_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = sva_evt_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    output logic   full,
    output logic   out_valid,
    output entry_t out_data,
    input  logic   out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic          pop, push_acc;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = out_valid && out_ready;
    assign push_acc = push && (!full || pop);
    assign wr_ptr_n = wr_ptr + (AW+1)'(push_acc);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head mirrors mem[rd_ptr]; when the entry being written becomes the head
    // this edge, it is taken from din since mem is not yet updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            out_valid <= (wr_ptr_n != rd_ptr_n);
            if (wr_ptr_n != rd_ptr_n)
                out_data <= (push_acc && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/sva_result_collector.sv
// Collects SVA succ/fail/lazy_succ pulses: timestamps, saturating counters, verdict
// and an event log. Optional first-fail capture under SVA_FIRST_FAIL_CAPTURE_EN.
module sva_result_collector
    import sva_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   grst,
    input  logic                   gclk_posedge_flag,
    input  logic                   succ,
    input  logic                   fail,
    input  logic                   lazy_succ,
    input  logic                   clr,
    sva_result_collector_if.master evt,
    output logic [CNT_WIDTH-1:0]   succ_cnt,
    output logic [CNT_WIDTH-1:0]   fail_cnt,
    output logic [CNT_WIDTH-1:0]   lazy_cnt,
    output logic [1:0]             status,
    output logic                   overflow,
    output logic                   first_fail_vld,
    output logic [TS_WIDTH-1:0]    first_fail_ts
);

    // Same layout as sva_evt_t, sized by this instance's TS_WIDTH.
    typedef struct packed {
        logic [2:0]          mask;
        logic [TS_WIDTH-1:0] ts;
    } evt_t;

    logic [TS_WIDTH-1:0] ts_q;
    sva_status_t         status_q, status_base, status_n;
    evt_t                evt_in, evt_head;
    logic                evt_any, fifo_full, drop;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic inc, input logic clear);
        logic [CNT_WIDTH-1:0] base;
        base = clear ? '0 : cur;
        return (inc && (base != '1)) ? base + CNT_WIDTH'(1) : base;
    endfunction

    assign evt_any = succ | fail | lazy_succ;

    always_comb begin
        evt_in                = '0;
        evt_in.mask[EVT_SUCC] = succ;
        evt_in.mask[EVT_FAIL] = fail;
        evt_in.mask[EVT_LAZY] = lazy_succ;
        evt_in.ts             = ts_q;
    end

    sva_evt_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (evt_t)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (evt_any),
        .din       (evt_in),
        .full      (fifo_full),
        .out_valid (evt.evt_valid),
        .out_data  (evt_head),
        .out_ready (evt.evt_ready)
    );

    assign evt.evt_mask = evt_head.mask;
    assign evt.evt_ts   = evt_head.ts;
    assign drop         = evt_any && fifo_full && !(evt.evt_valid && evt.evt_ready);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)             ts_q <= '0;
        else if (grst)              ts_q <= '0;
        else if (gclk_posedge_flag) ts_q <= ts_q + TS_WIDTH'(1);
    end

    // clr resets the base first so a same-cycle event lands on cleared state.
    always_comb begin
        status_base = clr ? EMPTY : status_q;
        status_n    = status_base;
        case (status_base)
            EMPTY:           if (succ || lazy_succ) status_n = PASSING;
            PASSING, FAILED: status_n = status_base;
            default:         status_n = EMPTY;
        endcase
        if (fail) status_n = FAILED;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
            status_q <= EMPTY;
            overflow <= 1'b0;
        end else begin
            succ_cnt <= cnt_next(succ_cnt, succ, clr);
            fail_cnt <= cnt_next(fail_cnt, fail, clr);
            lazy_cnt <= cnt_next(lazy_cnt, lazy_succ, clr);
            status_q <= status_n;
            overflow <= (overflow && !clr) || drop;
        end
    end

    assign status = status_q;

`ifdef SVA_FIRST_FAIL_CAPTURE_EN
    logic                ff_vld_q;
    logic [TS_WIDTH-1:0] ff_ts_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ff_vld_q <= 1'b0;
            ff_ts_q  <= '0;
        end else if (fail && (clr || !ff_vld_q)) begin
            ff_vld_q <= 1'b1;
            ff_ts_q  <= ts_q;
        end else if (clr) begin
            ff_vld_q <= 1'b0;
            ff_ts_q  <= '0;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_ts  = ff_ts_q;
`else
    assign first_fail_vld = 1'b0;
    assign first_fail_ts  = '0;
`endif

endmodule

// File: tb/tb_sva_result_collector.sv
// Self-checking bench for sva_result_collector: vector table plus event-log
// scoreboard on a default instance, and a narrow instance for saturation/wrap.
module tb_sva_result_collector;
    import sva_pkg::*;

`ifdef SVA_FIRST_FAIL_CAPTURE_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // default-parameter instance
    logic        a_rst_n, a_grst, a_flag, a_succ, a_fail, a_lazy, a_clr;
    logic [15:0] a_succ_cnt, a_fail_cnt, a_lazy_cnt, a_ff_ts;
    logic [1:0]  a_status;
    logic        a_ovf, a_ff_vld;
    sva_result_collector_if #(.TS_WIDTH(16)) a_if ();

    sva_result_collector #(.CNT_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
        .sys_clk(clk), .sys_rst_n(a_rst_n), .grst(a_grst), .gclk_posedge_flag(a_flag),
        .succ(a_succ), .fail(a_fail), .lazy_succ(a_lazy), .clr(a_clr), .evt(a_if),
        .succ_cnt(a_succ_cnt), .fail_cnt(a_fail_cnt), .lazy_cnt(a_lazy_cnt),
        .status(a_status), .overflow(a_ovf), .first_fail_vld(a_ff_vld), .first_fail_ts(a_ff_ts)
    );

    // narrow instance: 4-bit counters and timestamp
    logic       b_rst_n, b_grst, b_flag, b_succ, b_fail, b_lazy, b_clr;
    logic [3:0] b_succ_cnt, b_fail_cnt, b_lazy_cnt, b_ff_ts;
    logic [1:0] b_status;
    logic       b_ovf, b_ff_vld;
    sva_result_collector_if #(.TS_WIDTH(4)) b_if ();

    sva_result_collector #(.CNT_WIDTH(4), .TS_WIDTH(4), .FIFO_DEPTH(8)) dut_b (
        .sys_clk(clk), .sys_rst_n(b_rst_n), .grst(b_grst), .gclk_posedge_flag(b_flag),
        .succ(b_succ), .fail(b_fail), .lazy_succ(b_lazy), .clr(b_clr), .evt(b_if),
        .succ_cnt(b_succ_cnt), .fail_cnt(b_fail_cnt), .lazy_cnt(b_lazy_cnt),
        .status(b_status), .overflow(b_ovf), .first_fail_vld(b_ff_vld), .first_fail_ts(b_ff_ts)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard of expected log entries for dut_a
    typedef struct packed {
        logic [2:0]  mask;
        logic [15:0] ts;
    } exp_evt_t;

    exp_evt_t sb[$];
    int       occ_a  = 0;
    int       ts_a   = 0;
    int       pops_a = 0;

    always @(negedge clk) begin : mon_a
        exp_evt_t e;
        if (a_rst_n && a_if.evt_valid && a_if.evt_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_extra: got mask %b ts %0d, expected no entry",
                         a_if.evt_mask, a_if.evt_ts);
            end else begin
                e = sb.pop_front();
                chk("fifo_entry", {45'd0, a_if.evt_mask, a_if.evt_ts}, {45'd0, e});
                pops_a++;
            end
        end
    end

    task automatic step_a(input logic fl, input logic gr, input logic s, input logic f,
                          input logic l, input logic c);
        logic pop;
        pop    = a_if.evt_valid && a_if.evt_ready;
        a_flag = fl; a_grst = gr; a_succ = s; a_fail = f; a_lazy = l; a_clr = c;
        if ((s || f || l) && (occ_a < 8 || pop)) begin
            sb.push_back({l, f, s, 16'(ts_a)});
            occ_a++;
        end
        if (pop) occ_a--;
        if (gr)      ts_a = 0;
        else if (fl) ts_a = (ts_a + 1) % 65536;
        @(posedge clk);
        #1;
        a_flag = 0; a_grst = 0; a_succ = 0; a_fail = 0; a_lazy = 0; a_clr = 0;
    endtask

    task automatic drain_a(input int budget);
        a_if.evt_ready = 1'b1;
        for (int i = 0; i < budget && (sb.size() != 0 || a_if.evt_valid); i++)
            step_a(0, 0, 0, 0, 0, 0);
        chk("drain_done", {62'd0, sb.size() == 0, a_if.evt_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic step_b(input logic fl, input logic s, input logic f,
                          input logic l, input logic c);
        b_flag = fl; b_succ = s; b_fail = f; b_lazy = l; b_clr = c;
        @(posedge clk);
        #1;
        b_flag = 0; b_succ = 0; b_fail = 0; b_lazy = 0; b_clr = 0;
    endtask

    typedef struct {
        int fl, gr, s, f, l, c;
        int e_succ, e_fail, e_lazy, e_st, e_ffv, e_ffts;
    } vec_t;

    vec_t vecs[15];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0};
        vecs[3]  = '{0, 0, 1, 0, 0, 0,  1, 0, 0, 1,  0, 0};
        vecs[4]  = '{1, 0, 0, 0, 1, 0,  1, 0, 1, 1,  0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 0,  1, 0, 1, 1,  0, 0};
        vecs[6]  = '{0, 0, 1, 1, 0, 0,  2, 1, 1, 2,  1, 5};
        vecs[7]  = '{1, 0, 0, 0, 1, 0,  2, 1, 2, 2,  1, 5};
        vecs[8]  = '{1, 1, 0, 0, 0, 0,  2, 1, 2, 2,  1, 5};
        vecs[9]  = '{0, 0, 0, 1, 0, 0,  2, 2, 2, 2,  1, 5};
        vecs[10] = '{0, 0, 0, 0, 1, 1,  0, 0, 1, 1,  0, 0};
        vecs[11] = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 1,  0, 0};
        vecs[12] = '{0, 0, 0, 1, 0, 0,  0, 1, 1, 2,  1, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0};
        vecs[14] = '{0, 0, 1, 0, 1, 0,  1, 0, 1, 1,  0, 0};

        a_rst_n = 0; a_grst = 0; a_flag = 0; a_succ = 0; a_fail = 0; a_lazy = 0; a_clr = 0;
        b_rst_n = 0; b_grst = 0; b_flag = 0; b_succ = 0; b_fail = 0; b_lazy = 0; b_clr = 0;
        a_if.evt_ready = 1'b0;
        b_if.evt_ready = 1'b1;

        #12;
        chk("rst_a_valid", {63'd0, a_if.evt_valid}, 64'd0);
        chk("rst_a_head", {45'd0, a_if.evt_mask, a_if.evt_ts}, 64'd0);
        chk("rst_a_cnts", {16'd0, a_succ_cnt, a_fail_cnt, a_lazy_cnt}, 64'd0);
        chk("rst_a_flags", {42'd0, a_status, a_ovf, a_ff_vld, a_ff_ts}, 64'd0);
        chk("rst_b_all", {40'd0, b_succ_cnt, b_fail_cnt, b_lazy_cnt, b_status, b_ovf,
                          b_ff_vld, b_if.evt_valid, b_ff_ts, 1'b0}, 64'd0);
        #10;
        a_rst_n = 1;
        b_rst_n = 1;
        a_if.evt_ready = 1'b1;

        // table: counters, verdict and first-fail capture; log drained continuously
        for (int i = 0; i < 15; i++) begin
            step_a(vecs[i].fl != 0, vecs[i].gr != 0, vecs[i].s != 0, vecs[i].f != 0,
                   vecs[i].l != 0, vecs[i].c != 0);
            chk($sformatf("vec%0d_cnts", i), {16'd0, a_succ_cnt, a_fail_cnt, a_lazy_cnt},
                {16'd0, 16'(vecs[i].e_succ), 16'(vecs[i].e_fail), 16'(vecs[i].e_lazy)});
            chk($sformatf("vec%0d_state", i), {42'd0, a_status, a_ovf, a_ff_vld, a_ff_ts},
                {42'd0, 2'(vecs[i].e_st), 1'b0, (vecs[i].e_ffv != 0) && FF_EN,
                 FF_EN ? 16'(vecs[i].e_ffts) : 16'd0});
        end
        drain_a(20);

        // 10 events with the consumer stalled: 8 kept, 2 dropped
        a_if.evt_ready = 1'b0;
        step_a(0, 0, 0, 0, 0, 1);
        chk("pre_push_valid", {63'd0, a_if.evt_valid}, 64'd0);
        step_a(1, 0, 1, 0, 0, 0);
        chk("no_bypass_valid", {63'd0, a_if.evt_valid}, 64'd1);
        chk("head_first", {45'd0, a_if.evt_mask, a_if.evt_ts}, {45'd0, 3'b001, 16'd1});
        for (int i = 0; i < 9; i++) step_a(1, 0, 1, 0, 0, 0);
        chk("head_hold", {45'd0, a_if.evt_mask, a_if.evt_ts}, {45'd0, 3'b001, 16'd1});
        chk("ovf_succ_cnt", {48'd0, a_succ_cnt}, 64'd10);
        chk("ovf_flag", {63'd0, a_ovf}, 64'd1);
        pops_a = 0;
        drain_a(30);
        chk("ovf_drained", 64'(pops_a), 64'd8);

        // full FIFO with push and pop in the same cycle
        a_if.evt_ready = 1'b0;
        step_a(0, 0, 0, 0, 0, 1);
        chk("clr_ovf", {63'd0, a_ovf}, 64'd0);
        for (int i = 0; i < 8; i++) step_a(1, 0, 1, 0, 0, 0);
        a_if.evt_ready = 1'b1;
        step_a(1, 0, 1, 0, 0, 0);
        a_if.evt_ready = 1'b0;
        chk("pushpop_ovf", {63'd0, a_ovf}, 64'd0);
        chk("pushpop_head", {48'd0, a_if.evt_ts}, 64'd12);
        step_a(0, 0, 1, 0, 0, 0);
        chk("still_full_ovf", {63'd0, a_ovf}, 64'd1);
        pops_a = 0;
        drain_a(30);
        chk("pushpop_drained", 64'(pops_a), 64'd8);

        // asynchronous reset in the middle of a drain
        a_if.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) step_a(0, 0, 1, 0, 0, 0);
        a_if.evt_ready = 1'b1;
        step_a(0, 0, 0, 0, 0, 0);
        chk("pre_reset_valid", {63'd0, a_if.evt_valid}, 64'd1);
        #3;
        a_rst_n = 0;
        #1;
        chk("mid_rst_valid", {63'd0, a_if.evt_valid}, 64'd0);
        chk("mid_rst_head", {45'd0, a_if.evt_mask, a_if.evt_ts}, 64'd0);
        chk("mid_rst_cnts", {16'd0, a_succ_cnt, a_fail_cnt, a_lazy_cnt}, 64'd0);
        chk("mid_rst_flags", {42'd0, a_status, a_ovf, a_ff_vld, a_ff_ts}, 64'd0);
        sb.delete();
        occ_a = 0;
        ts_a  = 0;
        #2;
        a_rst_n = 1;
        step_a(0, 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 0, 0, 0);
        chk("post_rst_empty", {63'd0, a_if.evt_valid}, 64'd0);

        // narrow instance: saturation, clr with event, timestamp wrap
        for (int i = 0; i < 20; i++) step_b(0, 0, 1, 0, 0);
        chk("b_fail_sat", {60'd0, b_fail_cnt}, 64'd15);
        chk("b_status_failed", {62'd0, b_status}, 64'd2);
        chk("b_no_ovf", {63'd0, b_ovf}, 64'd0);
        step_b(0, 0, 0, 1, 1);
        chk("b_clr_lazy", {52'd0, b_lazy_cnt, b_fail_cnt, b_succ_cnt}, {52'd0, 4'd1, 4'd0, 4'd0});
        chk("b_clr_status", {62'd0, b_status}, 64'd1);
        for (int i = 0; i < 17; i++) step_b(1, 0, 0, 0, 0);
        step_b(0, 1, 0, 0, 0);
        chk("b_ts_wrap", {59'd0, b_if.evt_valid, b_if.evt_mask[0], b_if.evt_ts[2:0]},
            {59'd0, 1'b1, 1'b1, 3'd1});
        chk("b_ts_wrap_full", {60'd0, b_if.evt_ts}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
